// File: rtl/axi4_lite_arbiter.sv
// rtl/axi4_lite_arbiter.sv - two-master round-robin AXI4-Lite arbiter, one transaction outstanding
// Optional per-master grant counters are enabled by defining ARB_STATS_EN.
module axi4_lite_arbiter #(
    parameter int  DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = (DATA_WIDTH == 32) ? 32 : 64,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    input  logic                  i_s0_awvalid,
    output logic                  o_s0_awready,
    input  logic [ADDR_WIDTH-1:0] i_s0_awaddr,
    input  logic                  i_s0_wvalid,
    output logic                  o_s0_wready,
    input  logic [DATA_WIDTH-1:0] i_s0_wdata,
    input  logic [STRB_WIDTH-1:0] i_s0_wstrb,
    output logic                  o_s0_bvalid,
    input  logic                  i_s0_bready,
    output logic [1:0]            o_s0_bresp,
    input  logic                  i_s0_arvalid,
    output logic                  o_s0_arready,
    input  logic [ADDR_WIDTH-1:0] i_s0_araddr,
    output logic                  o_s0_rvalid,
    input  logic                  i_s0_rready,
    output logic [DATA_WIDTH-1:0] o_s0_rdata,
    output logic [1:0]            o_s0_rresp,
    input  logic                  i_s1_awvalid,
    output logic                  o_s1_awready,
    input  logic [ADDR_WIDTH-1:0] i_s1_awaddr,
    input  logic                  i_s1_wvalid,
    output logic                  o_s1_wready,
    input  logic [DATA_WIDTH-1:0] i_s1_wdata,
    input  logic [STRB_WIDTH-1:0] i_s1_wstrb,
    output logic                  o_s1_bvalid,
    input  logic                  i_s1_bready,
    output logic [1:0]            o_s1_bresp,
    input  logic                  i_s1_arvalid,
    output logic                  o_s1_arready,
    input  logic [ADDR_WIDTH-1:0] i_s1_araddr,
    output logic                  o_s1_rvalid,
    input  logic                  i_s1_rready,
    output logic [DATA_WIDTH-1:0] o_s1_rdata,
    output logic [1:0]            o_s1_rresp,
    output logic                  o_m_awvalid,
    input  logic                  i_m_awready,
    output logic [ADDR_WIDTH-1:0] o_m_awaddr,
    output logic                  o_m_wvalid,
    input  logic                  i_m_wready,
    output logic [DATA_WIDTH-1:0] o_m_wdata,
    output logic [STRB_WIDTH-1:0] o_m_wstrb,
    input  logic                  i_m_bvalid,
    output logic                  o_m_bready,
    input  logic [1:0]            i_m_bresp,
    output logic                  o_m_arvalid,
    input  logic                  i_m_arready,
    output logic [ADDR_WIDTH-1:0] o_m_araddr,
    input  logic                  i_m_rvalid,
    output logic                  o_m_rready,
    input  logic [DATA_WIDTH-1:0] i_m_rdata,
    input  logic [1:0]            i_m_rresp,
    output logic                  o_busy,
    output logic [1:0]            o_grant_id
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]           o_gnt_cnt0,
    output logic [15:0]           o_gnt_cnt1
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_RADDR, S_RDATA} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_ptr, w_ptr_nxt;
    logic [1:0] r_grant_id, w_grant_nxt;
    logic       r_aw_done, w_aw_done_nxt;
    logic       r_w_done, w_w_done_nxt;

    logic [3:0] w_req;
    logic       w_win_vld;
    logic [1:0] w_win;
    logic       w_grant_evt;

    logic w_st_waddr, w_st_wresp, w_st_raddr, w_st_rdata;
    logic w_sel_m1;
    logic w_aw_open, w_w_open;
    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_awready, w_wready, w_arready, w_bvalid, w_rvalid;

    logic                  w_sel_awvalid, w_sel_wvalid, w_sel_bready, w_sel_arvalid, w_sel_rready;
    logic [ADDR_WIDTH-1:0] w_sel_awaddr, w_sel_araddr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [STRB_WIDTH-1:0] w_sel_wstrb;

    // Slot index equals {master, is_read}, so the winning slot is the grant id.
    assign w_req = {i_s1_arvalid, i_s1_awvalid, i_s0_arvalid, i_s0_awvalid};

    always_comb begin
        w_win_vld = 1'b0;
        w_win     = r_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (w_req[r_ptr + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win     = r_ptr + 2'(k);
            end
        end
    end

    assign w_st_waddr  = (r_state == S_WADDR);
    assign w_st_wresp  = (r_state == S_WRESP);
    assign w_st_raddr  = (r_state == S_RADDR);
    assign w_st_rdata  = (r_state == S_RDATA);
    assign w_grant_evt = (r_state == S_IDLE) && w_win_vld;
    assign w_sel_m1    = r_grant_id[1];

    assign w_sel_awvalid = w_sel_m1 ? i_s1_awvalid : i_s0_awvalid;
    assign w_sel_awaddr  = w_sel_m1 ? i_s1_awaddr  : i_s0_awaddr;
    assign w_sel_wvalid  = w_sel_m1 ? i_s1_wvalid  : i_s0_wvalid;
    assign w_sel_wdata   = w_sel_m1 ? i_s1_wdata   : i_s0_wdata;
    assign w_sel_wstrb   = w_sel_m1 ? i_s1_wstrb   : i_s0_wstrb;
    assign w_sel_bready  = w_sel_m1 ? i_s1_bready  : i_s0_bready;
    assign w_sel_arvalid = w_sel_m1 ? i_s1_arvalid : i_s0_arvalid;
    assign w_sel_araddr  = w_sel_m1 ? i_s1_araddr  : i_s0_araddr;
    assign w_sel_rready  = w_sel_m1 ? i_s1_rready  : i_s0_rready;

    // Each write channel closes independently once its handshake is done.
    assign w_aw_open = w_st_waddr & ~r_aw_done;
    assign w_w_open  = w_st_waddr & ~r_w_done;

    assign o_m_awvalid = w_aw_open & w_sel_awvalid;
    assign o_m_awaddr  = w_aw_open ? w_sel_awaddr : '0;
    assign o_m_wvalid  = w_w_open & w_sel_wvalid;
    assign o_m_wdata   = w_w_open ? w_sel_wdata : '0;
    assign o_m_wstrb   = w_w_open ? w_sel_wstrb : '0;
    assign o_m_bready  = w_st_wresp & w_sel_bready;
    assign o_m_arvalid = w_st_raddr & w_sel_arvalid;
    assign o_m_araddr  = w_st_raddr ? w_sel_araddr : '0;
    assign o_m_rready  = w_st_rdata & w_sel_rready;

    assign w_awready = w_aw_open & i_m_awready;
    assign w_wready  = w_w_open & i_m_wready;
    assign w_arready = w_st_raddr & i_m_arready;
    assign w_bvalid  = w_st_wresp & i_m_bvalid;
    assign w_rvalid  = w_st_rdata & i_m_rvalid;

    assign o_s0_awready = w_awready & ~w_sel_m1;
    assign o_s0_wready  = w_wready & ~w_sel_m1;
    assign o_s0_arready = w_arready & ~w_sel_m1;
    assign o_s0_bvalid  = w_bvalid & ~w_sel_m1;
    assign o_s0_bresp   = (w_st_wresp & ~w_sel_m1) ? i_m_bresp : 2'b00;
    assign o_s0_rvalid  = w_rvalid & ~w_sel_m1;
    assign o_s0_rdata   = (w_st_rdata & ~w_sel_m1) ? i_m_rdata : '0;
    assign o_s0_rresp   = (w_st_rdata & ~w_sel_m1) ? i_m_rresp : 2'b00;

    assign o_s1_awready = w_awready & w_sel_m1;
    assign o_s1_wready  = w_wready & w_sel_m1;
    assign o_s1_arready = w_arready & w_sel_m1;
    assign o_s1_bvalid  = w_bvalid & w_sel_m1;
    assign o_s1_bresp   = (w_st_wresp & w_sel_m1) ? i_m_bresp : 2'b00;
    assign o_s1_rvalid  = w_rvalid & w_sel_m1;
    assign o_s1_rdata   = (w_st_rdata & w_sel_m1) ? i_m_rdata : '0;
    assign o_s1_rresp   = (w_st_rdata & w_sel_m1) ? i_m_rresp : 2'b00;

    assign w_aw_hs = o_m_awvalid & i_m_awready;
    assign w_w_hs  = o_m_wvalid & i_m_wready;
    assign w_b_hs  = i_m_bvalid & o_m_bready;
    assign w_ar_hs = o_m_arvalid & i_m_arready;
    assign w_r_hs  = i_m_rvalid & o_m_rready;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_grant_nxt   = r_grant_id;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_grant_nxt = w_win;
                    w_ptr_nxt   = w_win + 2'd1;
                    w_state_nxt = w_win[0] ? S_RADDR : S_WADDR;
                end
            end
            S_WADDR: begin
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_nxt   = S_WRESP;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end else begin
                    w_aw_done_nxt = r_aw_done | w_aw_hs;
                    w_w_done_nxt  = r_w_done | w_w_hs;
                end
            end
            S_WRESP: if (w_b_hs) w_state_nxt = S_IDLE;
            S_RADDR: if (w_ar_hs) w_state_nxt = S_RDATA;
            S_RDATA: if (w_r_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state    <= S_IDLE;
            r_ptr      <= 2'd0;
            r_grant_id <= 2'd0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant_id <= w_grant_nxt;
            r_aw_done  <= w_aw_done_nxt;
            r_w_done   <= w_w_done_nxt;
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_grant_id = r_grant_id;

`ifdef ARB_STATS_EN
    logic [15:0] r_gnt_cnt0, r_gnt_cnt1;

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_gnt_cnt0 <= 16'd0;
            r_gnt_cnt1 <= 16'd0;
        end else if (w_grant_evt) begin
            if (w_win[1]) r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
            else          r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
        end
    end

    assign o_gnt_cnt0 = r_gnt_cnt0;
    assign o_gnt_cnt1 = r_gnt_cnt1;
`else
    logic w_unused_grant_evt;
    assign w_unused_grant_evt = w_grant_evt;
`endif

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb/tb_axi4_lite_arbiter.sv - directed self-checking bench for axi4_lite_arbiter
module tb_axi4_lite_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic [AW-1:0] s0_awaddr, s0_araddr;
    logic [DW-1:0] s0_wdata, s0_rdata;
    logic [SW-1:0] s0_wstrb;
    logic [1:0]    s0_bresp, s0_rresp;
    logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic [AW-1:0] s1_awaddr, s1_araddr;
    logic [DW-1:0] s1_wdata, s1_rdata;
    logic [SW-1:0] s1_wstrb;
    logic [1:0]    s1_bresp, s1_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bready, m_arvalid, m_arready, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic busy;
    logic [1:0] grant_id;
`ifdef ARB_STATS_EN
    logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

    // slave model state
    logic sl_bvalid, sl_rvalid, sl_aw_seen, sl_w_seen, sl_r_pend, r_stall;
    int sl_aw_cnt;
    logic [AW-1:0] sl_awaddr_last, sl_araddr_last;
    logic [DW-1:0] sl_wdata_last, cfg_rdata;
    logic [SW-1:0] sl_wstrb_last;
    logic [1:0] cfg_bresp, cfg_rresp;

    axi4_lite_arbiter #(.DATA_WIDTH(DW)) dut (
        .i_aclk(clk), .i_aresetn(rst_n),
        .i_s0_awvalid(s0_awvalid), .o_s0_awready(s0_awready), .i_s0_awaddr(s0_awaddr),
        .i_s0_wvalid(s0_wvalid), .o_s0_wready(s0_wready), .i_s0_wdata(s0_wdata), .i_s0_wstrb(s0_wstrb),
        .o_s0_bvalid(s0_bvalid), .i_s0_bready(s0_bready), .o_s0_bresp(s0_bresp),
        .i_s0_arvalid(s0_arvalid), .o_s0_arready(s0_arready), .i_s0_araddr(s0_araddr),
        .o_s0_rvalid(s0_rvalid), .i_s0_rready(s0_rready), .o_s0_rdata(s0_rdata), .o_s0_rresp(s0_rresp),
        .i_s1_awvalid(s1_awvalid), .o_s1_awready(s1_awready), .i_s1_awaddr(s1_awaddr),
        .i_s1_wvalid(s1_wvalid), .o_s1_wready(s1_wready), .i_s1_wdata(s1_wdata), .i_s1_wstrb(s1_wstrb),
        .o_s1_bvalid(s1_bvalid), .i_s1_bready(s1_bready), .o_s1_bresp(s1_bresp),
        .i_s1_arvalid(s1_arvalid), .o_s1_arready(s1_arready), .i_s1_araddr(s1_araddr),
        .o_s1_rvalid(s1_rvalid), .i_s1_rready(s1_rready), .o_s1_rdata(s1_rdata), .o_s1_rresp(s1_rresp),
        .o_m_awvalid(m_awvalid), .i_m_awready(m_awready), .o_m_awaddr(m_awaddr),
        .o_m_wvalid(m_wvalid), .i_m_wready(m_wready), .o_m_wdata(m_wdata), .o_m_wstrb(m_wstrb),
        .i_m_bvalid(sl_bvalid), .o_m_bready(m_bready), .i_m_bresp(cfg_bresp),
        .o_m_arvalid(m_arvalid), .i_m_arready(m_arready), .o_m_araddr(m_araddr),
        .i_m_rvalid(sl_rvalid), .o_m_rready(m_rready), .i_m_rdata(cfg_rdata), .i_m_rresp(cfg_rresp),
`ifdef ARB_STATS_EN
        .o_gnt_cnt0(gnt_cnt0), .o_gnt_cnt1(gnt_cnt1),
`endif
        .o_busy(busy), .o_grant_id(grant_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl_bvalid <= 1'b0; sl_rvalid <= 1'b0; sl_aw_seen <= 1'b0; sl_w_seen <= 1'b0;
            sl_r_pend <= 1'b0; sl_aw_cnt <= 0;
            sl_awaddr_last <= '0; sl_araddr_last <= '0; sl_wdata_last <= '0; sl_wstrb_last <= '0;
        end else begin
            if (m_awvalid && m_awready) begin
                sl_aw_seen <= 1'b1; sl_aw_cnt <= sl_aw_cnt + 1; sl_awaddr_last <= m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                sl_w_seen <= 1'b1; sl_wdata_last <= m_wdata; sl_wstrb_last <= m_wstrb;
            end
            if ((sl_aw_seen || (m_awvalid && m_awready)) && (sl_w_seen || (m_wvalid && m_wready))) begin
                sl_bvalid <= 1'b1; sl_aw_seen <= 1'b0; sl_w_seen <= 1'b0;
            end else if (sl_bvalid && m_bready) begin
                sl_bvalid <= 1'b0;
            end
            if (m_arvalid && m_arready) begin
                sl_r_pend <= 1'b1; sl_araddr_last <= m_araddr;
            end
            if ((sl_r_pend || (m_arvalid && m_arready)) && !r_stall) begin
                sl_rvalid <= 1'b1; sl_r_pend <= 1'b0;
            end else if (sl_rvalid && m_rready) begin
                sl_rvalid <= 1'b0;
            end
        end
    end

    int errors = 0;
    int checks = 0;
    int n_cyc, n_gnt, n_s0_awr, s0_awr_cyc, n_s0_wr, s0_wr_cyc, first_bready_cyc;
    int n_s0_b, n_s1_r, n_s1_arr;
    int gnt_log[8];
    int gnt_cyc[8];
    logic prev_busy, hold, awv_at_c1;
    logic [AW-1:0] gnt_awaddr;
    logic [1:0] s0_bresp_got, s1_rresp_got;
    logic [DW-1:0] s1_rdata_got;

    task automatic clear_mon();
        n_cyc = 0; n_gnt = 0; n_s0_awr = 0; s0_awr_cyc = 0; n_s0_wr = 0; s0_wr_cyc = 0;
        first_bready_cyc = 0; n_s0_b = 0; n_s1_r = 0; n_s1_arr = 0; prev_busy = 1'b0;
        awv_at_c1 = 1'b0; gnt_awaddr = '0; s0_bresp_got = 2'b11; s1_rresp_got = 2'b00; s1_rdata_got = '0;
        for (int i = 0; i < 8; i++) begin gnt_log[i] = -1; gnt_cyc[i] = -1; end
    endtask

    task automatic drop_valids();
        s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
        s1_awvalid = 0; s1_wvalid = 0; s1_arvalid = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; hold = 1'b0; drop_valids();
        s0_bready = 1; s0_rready = 1; s1_bready = 1; s1_rready = 1;
        m_awready = 1; m_wready = 1; m_arready = 1; r_stall = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
    endtask

    // One clock: sample at the falling edge, retire handshaken requests after the rising edge.
    task automatic cyc();
        logic h0aw, h0w, h0ar, h1aw, h1w, h1ar;
        @(negedge clk);
        n_cyc++;
        if (n_cyc == 1) awv_at_c1 = m_awvalid;
        if (busy && !prev_busy && n_gnt < 8) begin
            gnt_log[n_gnt] = int'(grant_id); gnt_cyc[n_gnt] = n_cyc;
            if (n_gnt == 0) gnt_awaddr = m_awaddr;
            n_gnt++;
        end
        prev_busy = busy;
        if (s0_awready) begin n_s0_awr++; s0_awr_cyc = n_cyc; end
        if (s0_wready) begin n_s0_wr++; s0_wr_cyc = n_cyc; end
        if (s1_arready) n_s1_arr++;
        if (m_bready && first_bready_cyc == 0) first_bready_cyc = n_cyc;
        if (s0_bvalid && s0_bready) begin n_s0_b++; s0_bresp_got = s0_bresp; end
        if (s1_rvalid && s1_rready) begin n_s1_r++; s1_rdata_got = s1_rdata; s1_rresp_got = s1_rresp; end
        h0aw = s0_awvalid & s0_awready; h0w = s0_wvalid & s0_wready; h0ar = s0_arvalid & s0_arready;
        h1aw = s1_awvalid & s1_awready; h1w = s1_wvalid & s1_wready; h1ar = s1_arvalid & s1_arready;
        @(posedge clk);
        #1;
        if (!hold) begin
            if (h0aw) s0_awvalid = 0;
            if (h0w)  s0_wvalid = 0;
            if (h0ar) s0_arvalid = 0;
            if (h1aw) s1_awvalid = 0;
            if (h1w)  s1_wvalid = 0;
            if (h1ar) s1_arvalid = 0;
        end
    endtask

    function automatic logic [14:0] vr_bus();
        return {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
                s0_awready, s0_wready, s0_arready, s0_bvalid, s0_rvalid,
                s1_awready, s1_wready, s1_arready, s1_bvalid, s1_rvalid};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; hold = 1'b0; drop_valids();
        s0_bready = 1; s0_rready = 1; s1_bready = 1; s1_rready = 1;
        m_awready = 1; m_wready = 1; m_arready = 1; r_stall = 0;
        cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_rdata = '0;
        s0_awaddr = 32'h10; s0_awvalid = 1; s1_arvalid = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (vr_bus() !== 15'd0) begin errors++; $display("FAIL reset_handshakes: got %0h expected 0", vr_bus()); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL reset_busy_gid: got %0b/%0d expected 0/0", busy, grant_id); end
        checks++; if (m_awaddr !== '0) begin errors++; $display("FAIL reset_awaddr: got %0h expected 0", m_awaddr); end
        drop_valids();
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        repeat (3) cyc();
        checks++; if (n_gnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL idle_no_req: got grants=%0d busy=%0b expected 0/0", n_gnt, busy); end
    endtask

    task automatic test_write();
        apply_reset();
        s0_awaddr = 32'h10; s0_wdata = 32'hDEADBEEF; s0_wstrb = 4'hF;
        s0_awvalid = 1; s0_wvalid = 1;
        repeat (5) cyc();
        checks++; if (awv_at_c1 !== 1'b0) begin errors++; $display("FAIL wr_c1_awvalid: got %0b expected 0", awv_at_c1); end
        checks++; if (gnt_cyc[0] !== 2 || gnt_awaddr !== 32'h10) begin errors++; $display("FAIL wr_latency: got cyc=%0d addr=%0h expected 2/10", gnt_cyc[0], gnt_awaddr); end
        checks++; if (sl_wdata_last !== 32'hDEADBEEF || sl_wstrb_last !== 4'hF) begin errors++; $display("FAIL wr_data: got %0h/%0h expected deadbeef/f", sl_wdata_last, sl_wstrb_last); end
        checks++; if (n_s0_b !== 1 || s0_bresp_got !== 2'b00) begin errors++; $display("FAIL wr_bresp: got n=%0d resp=%0d expected 1/0", n_s0_b, s0_bresp_got); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0 || n_gnt !== 1) begin errors++; $display("FAIL wr_end: got busy=%0b gid=%0d n=%0d expected 0/0/1", busy, grant_id, n_gnt); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        cfg_rdata = 32'hCAFEF00D; cfg_rresp = 2'b10;
        s0_awaddr = 32'h20; s0_wdata = 32'h11223344; s0_wstrb = 4'h3;
        s1_araddr = 32'h44;
        s0_awvalid = 1; s0_wvalid = 1; s1_arvalid = 1;
        repeat (9) cyc();
        checks++; if (n_gnt !== 2 || gnt_log[0] !== 0 || gnt_log[1] !== 3) begin errors++; $display("FAIL sim_order: got n=%0d %0d,%0d expected 2 0,3", n_gnt, gnt_log[0], gnt_log[1]); end
        checks++; if (gnt_cyc[1] !== 5) begin errors++; $display("FAIL sim_gap: got %0d expected 5", gnt_cyc[1]); end
        checks++; if (s1_rdata_got !== 32'hCAFEF00D || s1_rresp_got !== 2'b10 || n_s1_r !== 1) begin errors++; $display("FAIL sim_rdata: got %0h/%0d n=%0d expected cafef00d/2 n=1", s1_rdata_got, s1_rresp_got, n_s1_r); end
        checks++; if (sl_araddr_last !== 32'h44 || sl_awaddr_last !== 32'h20) begin errors++; $display("FAIL sim_addr: got %0h/%0h expected 44/20", sl_araddr_last, sl_awaddr_last); end
        checks++; if (n_s1_arr !== 1) begin errors++; $display("FAIL sim_s1_arready: got %0d expected 1", n_s1_arr); end
    endtask

    task automatic test_back_to_back();
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        hold = 1'b1;
        s0_awvalid = 1; s0_wvalid = 1; s0_arvalid = 1;
        s1_awvalid = 1; s1_wvalid = 1; s1_arvalid = 1;
        repeat (15) cyc();
        checks++; if (gnt_cyc[0] !== 2) begin errors++; $display("FAIL b2b_first: got %0d expected 2", gnt_cyc[0]); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (gnt_log[i] !== exp_ids[i]) begin errors++; $display("FAIL b2b_gid%0d: got %0d expected %0d", i, gnt_log[i], exp_ids[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (gnt_cyc[i+1] - gnt_cyc[i] !== 3) begin errors++; $display("FAIL b2b_gap%0d: got %0d expected 3", i, gnt_cyc[i+1] - gnt_cyc[i]); end
        end
        hold = 1'b0;
        drop_valids();
    endtask

    task automatic test_split_write();
        apply_reset();
        m_wready = 0;
        s0_awaddr = 32'h30; s0_wdata = 32'h5A5A5A5A; s0_wstrb = 4'hC;
        s0_awvalid = 1; s0_wvalid = 1;
        for (int i = 0; i < 8; i++) begin
            if (n_cyc == 4) m_wready = 1;
            cyc();
        end
        checks++; if (n_s0_awr !== 1 || s0_awr_cyc !== 2) begin errors++; $display("FAIL split_awready: got n=%0d cyc=%0d expected 1/2", n_s0_awr, s0_awr_cyc); end
        checks++; if (n_s0_wr !== 1 || s0_wr_cyc !== 5) begin errors++; $display("FAIL split_wready: got n=%0d cyc=%0d expected 1/5", n_s0_wr, s0_wr_cyc); end
        checks++; if (first_bready_cyc !== 6) begin errors++; $display("FAIL split_wresp: got %0d expected 6", first_bready_cyc); end
        checks++; if (sl_aw_cnt !== 1) begin errors++; $display("FAIL split_aw_dup: got %0d expected 1", sl_aw_cnt); end
        checks++; if (n_s0_b !== 1 || sl_wdata_last !== 32'h5A5A5A5A) begin errors++; $display("FAIL split_done: got n=%0d data=%0h expected 1/5a5a5a5a", n_s0_b, sl_wdata_last); end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        r_stall = 1;
        s0_araddr = 32'h80; s0_arvalid = 1;
        repeat (3) cyc();
        checks++; if (busy !== 1'b1 || m_rready !== 1'b1) begin errors++; $display("FAIL rdata_wait: got busy=%0b rready=%0b expected 1/1", busy, m_rready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vr_bus() !== 15'd0) begin errors++; $display("FAIL midrst_handshakes: got %0h expected 0", vr_bus()); end
        checks++; if (busy !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL midrst_busy_gid: got %0b/%0d expected 0/0", busy, grant_id); end
        drop_valids(); r_stall = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        clear_mon();
        s0_awvalid = 1; s0_wvalid = 1; s1_awvalid = 1; s1_wvalid = 1;
        repeat (8) cyc();
        checks++; if (gnt_log[0] !== 0 || gnt_log[1] !== 2) begin errors++; $display("FAIL midrst_ptr: got %0d,%0d expected 0,2", gnt_log[0], gnt_log[1]); end
        drop_valids();
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        apply_reset();
        for (int i = 0; i < 5; i++) begin s0_arvalid = 1; repeat (4) cyc(); end
        for (int i = 0; i < 3; i++) begin s1_arvalid = 1; repeat (4) cyc(); end
        checks++; if (gnt_cnt0 !== 16'd5 || gnt_cnt1 !== 16'd3) begin errors++; $display("FAIL stats_count: got %0d/%0d expected 5/3", gnt_cnt0, gnt_cnt1); end
        force dut.r_gnt_cnt0 = 16'hFFFF;
        @(posedge clk);
        #1 release dut.r_gnt_cnt0;
        s0_arvalid = 1; repeat (4) cyc();
        checks++; if (gnt_cnt0 !== 16'd0) begin errors++; $display("FAIL stats_wrap: got %0h expected 0", gnt_cnt0); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        s0_awaddr = '0; s0_wdata = '0; s0_wstrb = '0; s0_araddr = '0;
        s1_awaddr = '0; s1_wdata = '0; s1_wstrb = '0; s1_araddr = '0;
        clear_mon();
        test_reset();
        test_write();
        test_simultaneous();
        test_back_to_back();
        test_split_write();
        test_reset_mid_read();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
